// File: rtl/bomb_manager.sv
// bomb_manager: two bomb slots (one per player) aged on a game tick, with
// cross-shaped explosions, chain detonation, player-hit flags and the
// flattened 2-bit bomb map (cell index = y*GRID+x) consumed by the renderer.
module bomb_manager #(
  parameter int TICK_CYCLES = 25000000,
  parameter int GRID        = 10
) (
  input  logic                   pixel_clk,
  input  logic                   rst,
  input  logic [3:0]             player1_x,
  input  logic [3:0]             player1_y,
  input  logic [3:0]             player2_x,
  input  logic [3:0]             player2_y,
  input  logic                   p1_place,
  input  logic                   p2_place,
  input  logic [GRID*GRID-1:0]   Arena_bit0,
  input  logic [GRID*GRID-1:0]   Arena_bit1,
  input  logic [1:0]             game_over,
  output logic [GRID*GRID-1:0]   Bomb_bit0,
  output logic [GRID*GRID-1:0]   Bomb_bit1,
  output logic                   p1_ack,
  output logic                   p2_ack,
  output logic                   player1_hit,
  output logic                   player2_hit
);

  localparam int CELLS = GRID * GRID;
  localparam int IW    = $clog2(CELLS);
  localparam int CW    = $clog2(TICK_CYCLES);
  localparam logic [3:0]    LAST   = 4'(GRID - 1);
  localparam logic [3:0]    SIDE   = 4'(GRID);
  localparam logic [CW-1:0] CNT_TOP = CW'(TICK_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, NEW, ARMED, EXPLODE} slot_state_t;

  function automatic logic [IW-1:0] cell_idx(input logic [3:0] x, input logic [3:0] y);
    return IW'(y) * IW'(GRID) + IW'(x);
  endfunction

  function automatic logic [CELLS-1:0] onehot(input logic [IW-1:0] idx);
    logic [CELLS-1:0] m;
    m      = '0;
    m[idx] = 1'b1;
    return m;
  endfunction

  // Own cell plus in-grid orthogonal neighbours that are not solid blocks.
  function automatic logic [CELLS-1:0] cross_of(input logic [3:0] x, input logic [3:0] y,
                                                 input logic [CELLS-1:0] blocks);
    logic [CELLS-1:0] m;
    logic [IW-1:0]    c;
    c = cell_idx(x, y);
    m = onehot(c);
    if (x != 4'd0 && !blocks[c - IW'(1)])    m[c - IW'(1)]    = 1'b1;
    if (x != LAST && !blocks[c + IW'(1)])    m[c + IW'(1)]    = 1'b1;
    if (y != 4'd0 && !blocks[c - IW'(GRID)]) m[c - IW'(GRID)] = 1'b1;
    if (y != LAST && !blocks[c + IW'(GRID)]) m[c + IW'(GRID)] = 1'b1;
    return m;
  endfunction

  // Lifecycle of an occupied slot; being caught in the other cross beats the tick.
  function automatic slot_state_t age_next(input slot_state_t s, input logic t, input logic chained);
    slot_state_t n;
    n = s;
    case (s)
      NEW:     n = chained ? EXPLODE : (t ? ARMED : NEW);
      ARMED:   n = (chained || t) ? EXPLODE : ARMED;
      EXPLODE: n = t ? IDLE : EXPLODE;
      default: n = IDLE;
    endcase
    return n;
  endfunction

  logic [CW-1:0]    tick_cnt;
  logic             frozen, tick;
  logic [CELLS-1:0] blk;

  slot_state_t      s1_state, s2_state, s1_state_nxt, s2_state_nxt;
  logic [3:0]       s1_x, s1_y, s2_x, s2_y;
  logic [3:0]       s1_x_nxt, s1_y_nxt, s2_x_nxt, s2_y_nxt;
  logic [IW-1:0]    s1_cell, s2_cell, p1_cell, p2_cell;
  logic [CELLS-1:0] cross1, cross2, cross_all, new_mask, armed_mask;
  logic             p1_in_grid, p2_in_grid, acc1, acc2;

  assign frozen = (game_over != 2'b00);
  assign tick   = !frozen && (tick_cnt == CNT_TOP);
  assign blk    = Arena_bit0 & ~Arena_bit1;

  // Game-tick prescaler, held while the game is frozen
  always_ff @(posedge pixel_clk) begin
    if (rst)
      tick_cnt <= '0;
    else if (!frozen)
      tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
  end

  // Slot state register
  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      s1_state <= IDLE;
      s2_state <= IDLE;
      s1_x     <= '0;
      s1_y     <= '0;
      s2_x     <= '0;
      s2_y     <= '0;
    end else begin
      s1_state <= s1_state_nxt;
      s2_state <= s2_state_nxt;
      s1_x     <= s1_x_nxt;
      s1_y     <= s1_y_nxt;
      s2_x     <= s2_x_nxt;
      s2_y     <= s2_y_nxt;
    end
  end

  // Decode crosses, occupancy masks and the accept decisions that drive the acks
  always_comb begin
    s1_cell    = cell_idx(s1_x, s1_y);
    s2_cell    = cell_idx(s2_x, s2_y);
    p1_cell    = cell_idx(player1_x, player1_y);
    p2_cell    = cell_idx(player2_x, player2_y);
    cross1     = (s1_state == EXPLODE) ? cross_of(s1_x, s1_y, blk) : '0;
    cross2     = (s2_state == EXPLODE) ? cross_of(s2_x, s2_y, blk) : '0;
    cross_all  = cross1 | cross2;
    new_mask   = ((s1_state == NEW)   ? onehot(s1_cell) : '0) |
                 ((s2_state == NEW)   ? onehot(s2_cell) : '0);
    armed_mask = ((s1_state == ARMED) ? onehot(s1_cell) : '0) |
                 ((s2_state == ARMED) ? onehot(s2_cell) : '0);
    p1_in_grid = (player1_x < SIDE) && (player1_y < SIDE);
    p2_in_grid = (player2_x < SIDE) && (player2_y < SIDE);
    acc1 = !rst && !frozen && p1_place && (s1_state == IDLE) && p1_in_grid &&
           !blk[p1_cell] &&
           !((s2_state != IDLE) && (s2_x == player1_x) && (s2_y == player1_y));
    acc2 = !rst && !frozen && p2_place && (s2_state == IDLE) && p2_in_grid &&
           !blk[p2_cell] &&
           !((s1_state != IDLE) && (s1_x == player2_x) && (s1_y == player2_y)) &&
           !(acc1 && (player1_x == player2_x) && (player1_y == player2_y));
    p1_ack = acc1;
    p2_ack = acc2;
  end

  // Next slot state: accept into an idle slot, otherwise chain or age
  always_comb begin
    s1_state_nxt = s1_state;
    s2_state_nxt = s2_state;
    s1_x_nxt     = s1_x;
    s1_y_nxt     = s1_y;
    s2_x_nxt     = s2_x;
    s2_y_nxt     = s2_y;
    if (!frozen) begin
      if (s1_state == IDLE) begin
        if (acc1) begin
          s1_state_nxt = NEW;
          s1_x_nxt     = player1_x;
          s1_y_nxt     = player1_y;
        end
      end else begin
        s1_state_nxt = age_next(s1_state, tick, cross2[s1_cell]);
      end
      if (s2_state == IDLE) begin
        if (acc2) begin
          s2_state_nxt = NEW;
          s2_x_nxt     = player2_x;
          s2_y_nxt     = player2_y;
        end
      end else begin
        s2_state_nxt = age_next(s2_state, tick, cross1[s2_cell]);
      end
    end
  end

  // Registered bomb map and hit flags (cross=3 dominates ARMED=2 and NEW=1)
  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      Bomb_bit0   <= '0;
      Bomb_bit1   <= '0;
      player1_hit <= 1'b0;
      player2_hit <= 1'b0;
    end else if (!frozen) begin
      Bomb_bit1   <= cross_all | armed_mask;
      Bomb_bit0   <= cross_all | new_mask;
      player1_hit <= p1_in_grid && cross_all[p1_cell];
      player2_hit <= p2_in_grid && cross_all[p2_cell];
    end
  end

endmodule
